// File: rtl/tape_in_cond_pkg.sv
// Shared tuning defaults and types for the tape input conditioner.
package tape_in_cond_pkg;

  localparam int unsigned FILT_MAX_DEF = 15;
  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned PER_W_DEF    = 16;

  // The first edge after reset only arms period measurement.
  typedef enum logic {
    ARM_IDLE = 1'b0,
    ARM_LIVE = 1'b1
  } arm_t;

endpackage

// File: rtl/tape_in_cond_filt.sv
// Two-flop resynchroniser plus saturating hysteresis counter producing the filtered tape level.
module tape_filt
  import tape_in_cond_pkg::*;
#(
  parameter int unsigned FILT_MAX = FILT_MAX_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic tape_raw,
  output logic tape_in,
  output logic tape_nxt
);

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(FILT_MAX);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= tape_raw;
      s2 <= s1;
    end
  end

  // tape_nxt is exported so the parent can register the edge on the same clock.
  always_comb begin
    cnt_nxt = cnt;
    if (s2) begin
      if (cnt != CMAX) cnt_nxt = cnt + ONE;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - ONE;
    end
    tape_nxt = tape_in;
    if (cnt_nxt == CMAX)    tape_nxt = 1'b1;
    else if (cnt_nxt == '0) tape_nxt = 1'b0;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tape_in <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      tape_in <= tape_nxt;
    end
  end

endmodule

// File: rtl/tape_in_cond.sv
// Tape input conditioner: filtered level, edge strobe and edge-to-edge period with valid/ack handoff.
module tape_in_cond
  import tape_in_cond_pkg::*;
#(
  parameter int unsigned FILT_MAX = FILT_MAX_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned PER_W    = PER_W_DEF
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             tape_raw,
  input  logic             tick_en,
  output logic             tape_in,
  output logic             edge_stb,
  output logic             edge_pol,
  output logic [PER_W-1:0] period,
  output logic             period_vld,
  input  logic             period_ack,
  output logic             ovf
);

  localparam logic [PER_W-1:0] PONE = PER_W'(1);

  logic             tape_nxt;
  logic             edge_det;
  logic             capture;
  logic             ack_eff;
  logic [PER_W-1:0] pcnt;
  arm_t             arm_q;
  arm_t             arm_d;

  tape_filt #(
    .FILT_MAX (FILT_MAX),
    .CNT_W    (CNT_W)
  ) u_filt (
    .fclk     (fclk),
    .rst_n    (rst_n),
    .tape_raw (tape_raw),
    .tape_in  (tape_in),
    .tape_nxt (tape_nxt)
  );

  always_comb begin
    arm_d    = arm_q;
    edge_det = tape_nxt ^ tape_in;
    capture  = 1'b0;
    ack_eff  = period_ack & period_vld;
    if (edge_det) begin
      arm_d   = ARM_LIVE;
      capture = (arm_q == ARM_LIVE);
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) arm_q <= ARM_IDLE;
    else        arm_q <= arm_d;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      edge_stb <= 1'b0;
      edge_pol <= 1'b0;
    end else begin
      edge_stb <= edge_det;
      if (edge_det) edge_pol <= tape_nxt;
    end
  end

  // Reload beats tick_en so the captured value is the count before this edge.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (edge_det) begin
      pcnt <= '0;
    end else if (tick_en && (pcnt != '1)) begin
      pcnt <= pcnt + PONE;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '0;
      period_vld <= 1'b0;
      ovf        <= 1'b0;
    end else if (capture) begin
      period     <= pcnt;
      period_vld <= 1'b1;
      if (ack_eff)         ovf <= 1'b0;
      else if (period_vld) ovf <= 1'b1;
    end else if (ack_eff) begin
      period_vld <= 1'b0;
      ovf        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tape_in_cond.sv
// Directed bench for tape_in_cond: default instance plus an 8-bit period instance for saturation.
module tb_tape_in_cond;

  logic        fclk;
  logic        rst_n;
  logic        tape_raw;
  logic        tick_en;
  logic        period_ack;

  logic        tape_in,  edge_stb,  edge_pol,  period_vld,  ovf;
  logic [15:0] period;
  logic        tape_in8, edge_stb8, edge_pol8, period_vld8, ovf8;
  logic [7:0]  period8;

  int n_checks = 0;
  int n_err    = 0;
  logic bad;

  tape_in_cond u_dut (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .tape_raw   (tape_raw),
    .tick_en    (tick_en),
    .tape_in    (tape_in),
    .edge_stb   (edge_stb),
    .edge_pol   (edge_pol),
    .period     (period),
    .period_vld (period_vld),
    .period_ack (period_ack),
    .ovf        (ovf)
  );

  tape_in_cond #(.PER_W(8)) u_dut8 (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .tape_raw   (tape_raw),
    .tick_en    (tick_en),
    .tape_in    (tape_in8),
    .edge_stb   (edge_stb8),
    .edge_pol   (edge_pol8),
    .period     (period8),
    .period_vld (period_vld8),
    .period_ack (period_ack),
    .ovf        (ovf8)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge fclk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tape_raw = 1'b0; tick_en = 1'b1; period_ack = 1'b0;
    #3;
    check("rst_tape_in", tape_in, 0);
    check("rst_edge_stb", edge_stb, 0);
    check("rst_period_vld", period_vld, 0);
    check("rst_period", period, 0);
    check("rst_ovf", ovf, 0);

    step(2); rst_n = 1'b1;
    step(1); tape_raw = 1'b1;                 // offsets below relative to this edge (j)
    step(16);                                  // j+16
    check("lat_before_tape", tape_in, 0);
    check("lat_before_stb", edge_stb, 0);
    step(1);                                   // j+17
    check("lat_tape_in", tape_in, 1);
    check("lat_edge_stb", edge_stb, 1);
    check("lat_edge_pol", edge_pol, 1);
    check("arm_no_vld", period_vld, 0);
    step(1);
    check("stb_one_cycle", edge_stb, 0);

    step(82); tape_raw = 1'b0;                 // j+100
    step(16);
    check("pre_cap_vld", period_vld, 0);
    step(1);                                   // j+117
    check("cap1_stb", edge_stb, 1);
    check("cap1_pol", edge_pol, 0);
    check("cap1_vld", period_vld, 1);
    check("cap1_period", period, 99);
    check("cap1_period8", period8, 99);
    check("cap1_ovf", ovf, 0);

    step(33); tape_raw = 1'b1;                 // j+150
    step(17);                                  // j+167
    check("cap2_period", period, 49);
    check("cap2_vld", period_vld, 1);
    check("cap2_ovf", ovf, 1);

    step(383); tape_raw = 1'b0;                // j+550
    step(17);                                  // j+567
    check("cap3_period", period, 399);
    check("sat_period8", period8, 255);
    check("cap3_ovf", ovf, 1);
    check("cap3_ovf8", ovf8, 1);

    period_ack = 1'b1; step(1); period_ack = 1'b0;   // j+568
    check("ack_vld", period_vld, 0);
    check("ack_ovf", ovf, 0);
    check("ack_vld8", period_vld8, 0);
    period_ack = 1'b1; step(1); period_ack = 1'b0;   // j+569
    check("idle_ack_vld", period_vld, 0);
    check("idle_ack_period", period, 399);

    step(31); tape_raw = 1'b1;                 // j+600
    step(14); tape_raw = 1'b0;                 // j+614
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (edge_stb || tape_in) bad = 1'b1;
    end                                        // j+644
    check("glitch14_reject", bad, 0);

    step(6); tape_raw = 1'b1;                  // j+650
    step(15); tape_raw = 1'b0;                 // j+665
    step(1);
    check("glitch15_before", tape_in, 0);
    step(1);                                   // j+667
    check("glitch15_tape", tape_in, 1);
    check("glitch15_stb", edge_stb, 1);
    check("glitch15_period", period, 99);
    check("glitch15_ovf", ovf, 0);

    step(14); period_ack = 1'b1;               // j+681
    step(1);                                   // j+682: capture with ack
    check("same_stb", edge_stb, 1);
    check("same_pol", edge_pol, 0);
    check("same_period", period, 14);
    check("same_vld", period_vld, 1);
    check("same_ovf", ovf, 0);
    step(1); period_ack = 1'b0;                // j+683
    check("same_ack_vld", period_vld, 0);

    step(17); tape_raw = 1'b1;                 // j+700
    step(17);                                  // j+717
    check("cap5_period", period, 34);
    check("cap5_vld", period_vld, 1);

    step(33); tape_raw = 1'b0;                 // j+750
    step(8); #2; rst_n = 1'b0; #1;
    check("midrst_tape", tape_in, 0);
    check("midrst_pol", edge_pol, 0);
    check("midrst_period", period, 0);
    check("midrst_vld", period_vld, 0);

    step(2); rst_n = 1'b1;
    step(1); tape_raw = 1'b1;                  // J
    step(17);                                  // J+17
    check("rearm_stb", edge_stb, 1);
    check("rearm_no_vld", period_vld, 0);

    tick_en = 1'b0; step(20);
    tick_en = 1'b1; step(10);
    tick_en = 1'b0; step(53); tape_raw = 1'b0; // J+100
    step(17);                                  // J+117
    check("tick_period", period, 10);
    check("tick_vld", period_vld, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
